aes_inv_sub_bytes: RTL

Iterative InvSubBytes engine for the AES-128 decryption datapath. Accepts a 128-bit state over a valid/ready handshake and substitutes every byte through the AES inverse S-box, BYTES_PER_CYCLE bytes per clock. Returns the result over a second valid/ready handshake. Sits in the inverse-round loop, opposite the forward `sbox` used by encryption.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/inv_sbox.sv | 58 +++++
 rtl/aes_inv_sub_bytes.sv | 135 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the decryption datapath:
//   - AES_BLOCK_BITS / AES_STATE_BYTES sizing constants
//   - aes_state_t : 16 x 8-bit state, element [15] is byte s0 (bits [127:120]),
//                   element [0] is byte s15 (bits [7:0])
//   - aes_fsm_e   : IDLE / BUSY / DONE engine states
//   - inv_shift_rows_src() : InvShiftRows source-byte index
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_BLOCK_BITS  = 128;
   localparam int AES_STATE_BYTES = 16;

   typedef logic [7:0] aes_byte_t;

   typedef aes_byte_t [AES_STATE_BYTES-1:0] aes_state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } aes_fsm_e;

   // For output byte k (row r = k%4, column c = k/4) return the index of the
   // substituted byte it takes: out[r][c] = sub[r][(c - r) mod 4].
   function automatic int unsigned inv_shift_rows_src(input int unsigned k);
      int unsigned r;
      int unsigned c;
      r = k % 4;
      c = k / 4;
      return 4 * ((c + 4 - r) % 4) + r;
   endfunction

endpackage

// File: rtl/inv_sbox.sv
// -----------------------------------------------------------------------------
// inv_sbox
// Combinational AES inverse S-box (exact inverse of the forward SubBytes box).
// Ports:
//   byte_i  in  8  byte to substitute
//   byte_o  out 8  inv_sbox(byte_i)
// -----------------------------------------------------------------------------
module inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o
);

   aes_byte_t sub;

   always_comb begin
      sub = 8'h00;
      case (byte_i)
         8'h00: sub = 8'h52; 8'h01: sub = 8'h09; 8'h02: sub = 8'h6a; 8'h03: sub = 8'hd5; 8'h04: sub = 8'h30; 8'h05: sub = 8'h36; 8'h06: sub = 8'ha5; 8'h07: sub = 8'h38;
         8'h08: sub = 8'hbf; 8'h09: sub = 8'h40; 8'h0a: sub = 8'ha3; 8'h0b: sub = 8'h9e; 8'h0c: sub = 8'h81; 8'h0d: sub = 8'hf3; 8'h0e: sub = 8'hd7; 8'h0f: sub = 8'hfb;
         8'h10: sub = 8'h7c; 8'h11: sub = 8'he3; 8'h12: sub = 8'h39; 8'h13: sub = 8'h82; 8'h14: sub = 8'h9b; 8'h15: sub = 8'h2f; 8'h16: sub = 8'hff; 8'h17: sub = 8'h87;
         8'h18: sub = 8'h34; 8'h19: sub = 8'h8e; 8'h1a: sub = 8'h43; 8'h1b: sub = 8'h44; 8'h1c: sub = 8'hc4; 8'h1d: sub = 8'hde; 8'h1e: sub = 8'he9; 8'h1f: sub = 8'hcb;
         8'h20: sub = 8'h54; 8'h21: sub = 8'h7b; 8'h22: sub = 8'h94; 8'h23: sub = 8'h32; 8'h24: sub = 8'ha6; 8'h25: sub = 8'hc2; 8'h26: sub = 8'h23; 8'h27: sub = 8'h3d;
         8'h28: sub = 8'hee; 8'h29: sub = 8'h4c; 8'h2a: sub = 8'h95; 8'h2b: sub = 8'h0b; 8'h2c: sub = 8'h42; 8'h2d: sub = 8'hfa; 8'h2e: sub = 8'hc3; 8'h2f: sub = 8'h4e;
         8'h30: sub = 8'h08; 8'h31: sub = 8'h2e; 8'h32: sub = 8'ha1; 8'h33: sub = 8'h66; 8'h34: sub = 8'h28; 8'h35: sub = 8'hd9; 8'h36: sub = 8'h24; 8'h37: sub = 8'hb2;
         8'h38: sub = 8'h76; 8'h39: sub = 8'h5b; 8'h3a: sub = 8'ha2; 8'h3b: sub = 8'h49; 8'h3c: sub = 8'h6d; 8'h3d: sub = 8'h8b; 8'h3e: sub = 8'hd1; 8'h3f: sub = 8'h25;
         8'h40: sub = 8'h72; 8'h41: sub = 8'hf8; 8'h42: sub = 8'hf6; 8'h43: sub = 8'h64; 8'h44: sub = 8'h86; 8'h45: sub = 8'h68; 8'h46: sub = 8'h98; 8'h47: sub = 8'h16;
         8'h48: sub = 8'hd4; 8'h49: sub = 8'ha4; 8'h4a: sub = 8'h5c; 8'h4b: sub = 8'hcc; 8'h4c: sub = 8'h5d; 8'h4d: sub = 8'h65; 8'h4e: sub = 8'hb6; 8'h4f: sub = 8'h92;
         8'h50: sub = 8'h6c; 8'h51: sub = 8'h70; 8'h52: sub = 8'h48; 8'h53: sub = 8'h50; 8'h54: sub = 8'hfd; 8'h55: sub = 8'hed; 8'h56: sub = 8'hb9; 8'h57: sub = 8'hda;
         8'h58: sub = 8'h5e; 8'h59: sub = 8'h15; 8'h5a: sub = 8'h46; 8'h5b: sub = 8'h57; 8'h5c: sub = 8'ha7; 8'h5d: sub = 8'h8d; 8'h5e: sub = 8'h9d; 8'h5f: sub = 8'h84;
         8'h60: sub = 8'h90; 8'h61: sub = 8'hd8; 8'h62: sub = 8'hab; 8'h63: sub = 8'h00; 8'h64: sub = 8'h8c; 8'h65: sub = 8'hbc; 8'h66: sub = 8'hd3; 8'h67: sub = 8'h0a;
         8'h68: sub = 8'hf7; 8'h69: sub = 8'he4; 8'h6a: sub = 8'h58; 8'h6b: sub = 8'h05; 8'h6c: sub = 8'hb8; 8'h6d: sub = 8'hb3; 8'h6e: sub = 8'h45; 8'h6f: sub = 8'h06;
         8'h70: sub = 8'hd0; 8'h71: sub = 8'h2c; 8'h72: sub = 8'h1e; 8'h73: sub = 8'h8f; 8'h74: sub = 8'hca; 8'h75: sub = 8'h3f; 8'h76: sub = 8'h0f; 8'h77: sub = 8'h02;
         8'h78: sub = 8'hc1; 8'h79: sub = 8'haf; 8'h7a: sub = 8'hbd; 8'h7b: sub = 8'h03; 8'h7c: sub = 8'h01; 8'h7d: sub = 8'h13; 8'h7e: sub = 8'h8a; 8'h7f: sub = 8'h6b;
         8'h80: sub = 8'h3a; 8'h81: sub = 8'h91; 8'h82: sub = 8'h11; 8'h83: sub = 8'h41; 8'h84: sub = 8'h4f; 8'h85: sub = 8'h67; 8'h86: sub = 8'hdc; 8'h87: sub = 8'hea;
         8'h88: sub = 8'h97; 8'h89: sub = 8'hf2; 8'h8a: sub = 8'hcf; 8'h8b: sub = 8'hce; 8'h8c: sub = 8'hf0; 8'h8d: sub = 8'hb4; 8'h8e: sub = 8'he6; 8'h8f: sub = 8'h73;
         8'h90: sub = 8'h96; 8'h91: sub = 8'hac; 8'h92: sub = 8'h74; 8'h93: sub = 8'h22; 8'h94: sub = 8'he7; 8'h95: sub = 8'had; 8'h96: sub = 8'h35; 8'h97: sub = 8'h85;
         8'h98: sub = 8'he2; 8'h99: sub = 8'hf9; 8'h9a: sub = 8'h37; 8'h9b: sub = 8'he8; 8'h9c: sub = 8'h1c; 8'h9d: sub = 8'h75; 8'h9e: sub = 8'hdf; 8'h9f: sub = 8'h6e;
         8'ha0: sub = 8'h47; 8'ha1: sub = 8'hf1; 8'ha2: sub = 8'h1a; 8'ha3: sub = 8'h71; 8'ha4: sub = 8'h1d; 8'ha5: sub = 8'h29; 8'ha6: sub = 8'hc5; 8'ha7: sub = 8'h89;
         8'ha8: sub = 8'h6f; 8'ha9: sub = 8'hb7; 8'haa: sub = 8'h62; 8'hab: sub = 8'h0e; 8'hac: sub = 8'haa; 8'had: sub = 8'h18; 8'hae: sub = 8'hbe; 8'haf: sub = 8'h1b;
         8'hb0: sub = 8'hfc; 8'hb1: sub = 8'h56; 8'hb2: sub = 8'h3e; 8'hb3: sub = 8'h4b; 8'hb4: sub = 8'hc6; 8'hb5: sub = 8'hd2; 8'hb6: sub = 8'h79; 8'hb7: sub = 8'h20;
         8'hb8: sub = 8'h9a; 8'hb9: sub = 8'hdb; 8'hba: sub = 8'hc0; 8'hbb: sub = 8'hfe; 8'hbc: sub = 8'h78; 8'hbd: sub = 8'hcd; 8'hbe: sub = 8'h5a; 8'hbf: sub = 8'hf4;
         8'hc0: sub = 8'h1f; 8'hc1: sub = 8'hdd; 8'hc2: sub = 8'ha8; 8'hc3: sub = 8'h33; 8'hc4: sub = 8'h88; 8'hc5: sub = 8'h07; 8'hc6: sub = 8'hc7; 8'hc7: sub = 8'h31;
         8'hc8: sub = 8'hb1; 8'hc9: sub = 8'h12; 8'hca: sub = 8'h10; 8'hcb: sub = 8'h59; 8'hcc: sub = 8'h27; 8'hcd: sub = 8'h80; 8'hce: sub = 8'hec; 8'hcf: sub = 8'h5f;
         8'hd0: sub = 8'h60; 8'hd1: sub = 8'h51; 8'hd2: sub = 8'h7f; 8'hd3: sub = 8'ha9; 8'hd4: sub = 8'h19; 8'hd5: sub = 8'hb5; 8'hd6: sub = 8'h4a; 8'hd7: sub = 8'h0d;
         8'hd8: sub = 8'h2d; 8'hd9: sub = 8'he5; 8'hda: sub = 8'h7a; 8'hdb: sub = 8'h9f; 8'hdc: sub = 8'h93; 8'hdd: sub = 8'hc9; 8'hde: sub = 8'h9c; 8'hdf: sub = 8'hef;
         8'he0: sub = 8'ha0; 8'he1: sub = 8'he0; 8'he2: sub = 8'h3b; 8'he3: sub = 8'h4d; 8'he4: sub = 8'hae; 8'he5: sub = 8'h2a; 8'he6: sub = 8'hf5; 8'he7: sub = 8'hb0;
         8'he8: sub = 8'hc8; 8'he9: sub = 8'heb; 8'hea: sub = 8'hbb; 8'heb: sub = 8'h3c; 8'hec: sub = 8'h83; 8'hed: sub = 8'h53; 8'hee: sub = 8'h99; 8'hef: sub = 8'h61;
         8'hf0: sub = 8'h17; 8'hf1: sub = 8'h2b; 8'hf2: sub = 8'h04; 8'hf3: sub = 8'h7e; 8'hf4: sub = 8'hba; 8'hf5: sub = 8'h77; 8'hf6: sub = 8'hd6; 8'hf7: sub = 8'h26;
         8'hf8: sub = 8'he1; 8'hf9: sub = 8'h69; 8'hfa: sub = 8'h14; 8'hfb: sub = 8'h63; 8'hfc: sub = 8'h55; 8'hfd: sub = 8'h21; 8'hfe: sub = 8'h0c; 8'hff: sub = 8'h7d;
         default: sub = 8'h00;
      endcase
   end

   assign byte_o = sub;

endmodule

// File: rtl/aes_inv_sub_bytes.sv
// -----------------------------------------------------------------------------
// aes_inv_sub_bytes
// Iterative InvSubBytes engine for the AES-128 decryption round loop. A 128-bit
// state is accepted over a valid/ready handshake, substituted in place through
// the inverse S-box BYTES_PER_CYCLE bytes per clock, and returned over a second
// valid/ready handshake.
//
// Parameter:
//   BYTES_PER_CYCLE  bytes substituted per busy cycle (1, 2, 4, 8 or 16)
// Ports:
//   clk        in   1    clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    in_data valid
//   in_ready   out  1    engine idle and able to take a state
//   in_data    in   128  input state, s0 = [127:120] ... s15 = [7:0]
//   out_valid  out  1    out_data valid
//   out_ready  in   1    downstream accepts out_data
//   out_data   out  128  substituted state, same byte order
//   busy       out  1    substitution in progress
// Build option:
//   AES_INV_SUB_BYTES_SHIFTROWS_EN  when defined, out_data additionally carries
//                                   InvShiftRows (wiring only, same latency).
// -----------------------------------------------------------------------------
module aes_inv_sub_bytes
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [AES_BLOCK_BITS-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [AES_BLOCK_BITS-1:0] out_data,
   output logic                      busy
);

   localparam int N_GROUPS = AES_STATE_BYTES / BYTES_PER_CYCLE;
   localparam int CNT_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_GROUPS - 1);

   aes_fsm_e         fsm_q, fsm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   aes_state_t       st_q, st_d;
   logic             accept;

   logic [7:0] sb_in  [BYTES_PER_CYCLE];
   logic [7:0] sb_out [BYTES_PER_CYCLE];

   // State-register element holding byte (cnt*BPC + g); s0 lives in element 15.
   function automatic logic [3:0] group_slot(input logic [CNT_W-1:0] cnt, input int g);
      int k;
      k = int'(cnt) * BYTES_PER_CYCLE + g;
      return 4'(AES_STATE_BYTES - 1 - k);
   endfunction

   // Ready is forced low while reset is held so nothing can be accepted then.
   assign in_ready  = rst_n & (fsm_q == ST_IDLE);
   assign out_valid = (fsm_q == ST_DONE);
   assign busy      = (fsm_q == ST_BUSY);
   assign accept    = in_valid & in_ready;

   // ---- byte-group select feeding the S-box lanes ----
   always_comb begin
      for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
         sb_in[g] = st_q[group_slot(cnt_q, g)];
      end
   end

   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
      inv_sbox u_inv_sbox (
         .byte_i (sb_in[g]),
         .byte_o (sb_out[g])
      );
   end

   // ---- next-state / in-place write-back ----
   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      st_d  = st_q;
      unique case (fsm_q)
         ST_IDLE: begin
            if (accept) begin
               st_d  = in_data;
               cnt_d = '0;
               fsm_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
               st_d[group_slot(cnt_q, g)] = sb_out[g];
            end
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               fsm_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               fsm_d = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // ---- state registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= ST_IDLE;
         cnt_q <= '0;
         st_q  <= '0;
      end else begin
         fsm_q <= fsm_d;
         cnt_q <= cnt_d;
         st_q  <= st_d;
      end
   end

   // ---- output view of the state register ----
`ifdef AES_INV_SUB_BYTES_SHIFTROWS_EN
   for (genvar k = 0; k < AES_STATE_BYTES; k++) begin : g_isr
      localparam int SRC = int'(inv_shift_rows_src(k));
      assign out_data[AES_BLOCK_BITS-1-8*k -: 8] = st_q[AES_STATE_BYTES-1-SRC];
   end
`else
   assign out_data = st_q;
`endif

endmodule
